// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp sequencer: phase enumeration, default
// phase durations and the grant validity test.
package lamp_pkg;

  localparam int unsigned DEF_AMBER_CYCLES  = 3;
  localparam int unsigned DEF_ALLRED_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_AMBER  = 2'd2
  } lamp_state_e;

  // True only when exactly one approach is requested.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 8-bit down-counter that holds at zero; load wins over decrement.
module phase_timer #(
  parameter logic [7:0] RESET_VALUE = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (dec && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 8'd0);

endmodule

// File: rtl/lamp_sequencer.sv
// Turns a one-hot approach grant into safe lamp patterns: green, then a fixed
// amber stage, then an all-red clearance before the next approach goes green.
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int unsigned AMBER_CYCLES  = DEF_AMBER_CYCLES,
  parameter int unsigned ALLRED_CYCLES = DEF_ALLRED_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:1] grant,
  output logic [4:1] lamp_red,
  output logic [4:1] lamp_amber,
  output logic [4:1] lamp_green,
  output logic       switching,
  output logic       grant_err
);

  localparam logic [7:0] AMBER_LOAD  = 8'(AMBER_CYCLES - 1);
  localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_CYCLES - 1);

  lamp_state_e state_q, state_d;
  logic [4:1]  active_q, active_d;
  logic [4:1]  lamp_red_q, lamp_red_d;
  logic [4:1]  lamp_amber_q, lamp_amber_d;
  logic [4:1]  lamp_green_q, lamp_green_d;
  logic        switching_q, switching_d;
  logic        grant_err_q, grant_err_d;

  logic        grant_valid;
  logic        timer_load;
  logic [7:0]  timer_value;
  logic        timer_dec;
  logic        timer_zero;

  phase_timer #(
    .RESET_VALUE(ALLRED_LOAD)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .value(timer_value),
    .dec  (timer_dec),
    .zero (timer_zero)
  );

  always_comb begin
    grant_valid  = is_onehot(grant);
    grant_err_d  = (grant != 4'b0000) && !grant_valid;
    state_d      = state_q;
    active_d     = active_q;
    timer_load   = 1'b0;
    timer_value  = ALLRED_LOAD;
    timer_dec    = 1'b0;

    case (state_q)
      ST_ALLRED: begin
        if (timer_zero && grant_valid) begin
          state_d  = ST_GREEN;
          active_d = grant;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_GREEN: begin
        // Any difference, including an illegal grant, starts the hand-over.
        if (grant != active_q) begin
          state_d     = ST_AMBER;
          timer_load  = 1'b1;
          timer_value = AMBER_LOAD;
        end
      end
      ST_AMBER: begin
        if (!timer_zero) begin
          timer_dec = 1'b1;
        end else begin
          state_d     = ST_ALLRED;
          timer_load  = 1'b1;
          timer_value = ALLRED_LOAD;
        end
      end
      default: begin
        state_d    = ST_ALLRED;
        active_d   = 4'b0000;
        timer_load = 1'b1;
      end
    endcase

    // Lamps are decoded from the next state so they land in flops alongside it.
    lamp_red_d   = 4'b0000;
    lamp_amber_d = 4'b0000;
    lamp_green_d = 4'b0000;
    case (state_d)
      ST_GREEN: begin
        lamp_green_d = active_d;
        lamp_red_d   = ~active_d;
      end
      ST_AMBER: begin
        lamp_amber_d = active_d;
        lamp_red_d   = ~active_d;
      end
      default: begin
        lamp_red_d = 4'b1111;
      end
    endcase
    switching_d = (state_d != ST_GREEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ALLRED;
      active_q     <= 4'b0000;
      lamp_red_q   <= 4'b1111;
      lamp_amber_q <= 4'b0000;
      lamp_green_q <= 4'b0000;
      switching_q  <= 1'b1;
      grant_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      lamp_red_q   <= lamp_red_d;
      lamp_amber_q <= lamp_amber_d;
      lamp_green_q <= lamp_green_d;
      switching_q  <= switching_d;
      grant_err_q  <= grant_err_d;
    end
  end

  assign lamp_red   = lamp_red_q;
  assign lamp_amber = lamp_amber_q;
  assign lamp_green = lamp_green_q;
  assign switching  = switching_q;
  assign grant_err  = grant_err_q;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Self-checking bench for lamp_sequencer: directed hand-over scenarios followed
// by a long random grant stream, all checked against a phase/elapsed-time model.
module tb_lamp_sequencer;

  localparam int AMBER  = 3;
  localparam int ALLRED = 2;

  logic       clk;
  logic       rst;
  logic [3:0] grant;
  logic [3:0] lamp_red;
  logic [3:0] lamp_amber;
  logic [3:0] lamp_green;
  logic       switching;
  logic       grant_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected {red, amber, green, switching, grant_err} per sampled cycle.
  logic [13:0] exp_q[$];

  // Reference model: which phase is shown, how many edges it has lasted.
  int         m_phase;   // 0 = all red, 1 = green, 2 = amber
  int         m_elapsed;
  logic [3:0] m_active;
  logic       m_err;

  // Observed-run trackers for the timing invariants.
  int red_run;
  int amber_run;

  lamp_sequencer #(
    .AMBER_CYCLES (AMBER),
    .ALLRED_CYCLES(ALLRED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .lamp_red  (lamp_red),
    .lamp_amber(lamp_amber),
    .lamp_green(lamp_green),
    .switching (switching),
    .grant_err (grant_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_active  = 4'b0000;
    m_err     = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] g);
    bit valid;
    valid = ($countones(g) == 1);
    m_err = (g != 4'b0000) && !valid;
    case (m_phase)
      0: begin
        if (m_elapsed >= ALLRED - 1 && valid) begin
          m_phase = 1; m_active = g; m_elapsed = 0;
        end else if (m_elapsed < 1000) begin
          m_elapsed++;
        end
      end
      1: begin
        if (g != m_active) begin
          m_phase = 2; m_elapsed = 0;
        end
      end
      default: begin
        if (m_elapsed == AMBER - 1) begin
          m_phase = 0; m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
    endcase
  endtask

  function automatic logic [13:0] model_view();
    logic [3:0] r, a, gr;
    r = 4'b1111; a = 4'b0000; gr = 4'b0000;
    if (m_phase == 1) begin gr = m_active; r = ~m_active; end
    if (m_phase == 2) begin a  = m_active; r = ~m_active; end
    return {r, a, gr, (m_phase != 1), m_err};
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic compare_cycle();
    logic [13:0] e;
    e = exp_q.pop_front();
    check("lamp_red",   32'(lamp_red),   32'(e[13:10]));
    check("lamp_amber", 32'(lamp_amber), 32'(e[9:6]));
    check("lamp_green", 32'(lamp_green), 32'(e[5:2]));
    check("switching",  32'(switching),  32'(e[1]));
    check("grant_err",  32'(grant_err),  32'(e[0]));
    check("one_lamp_each", 32'(lamp_red ^ lamp_amber ^ lamp_green), 32'hf);
    check("lamp_overlap",
          32'((lamp_red & lamp_amber) | (lamp_red & lamp_green) | (lamp_amber & lamp_green)), 32'h0);
    check("single_go", 32'($countones(lamp_green | lamp_amber) <= 1), 32'h1);
    if (lamp_green != 4'b0000 && red_run > 0)
      check("clearance_before_green", 32'(red_run >= ALLRED), 32'h1);
    if (lamp_red == 4'b1111) red_run++; else red_run = 0;
    if (lamp_amber != 4'b0000) begin
      amber_run++;
    end else if (amber_run > 0) begin
      check("amber_length", 32'(amber_run), 32'(AMBER));
      amber_run = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] g);
    grant = g;
    @(posedge clk);
    model_edge(g);
    exp_q.push_back(model_view());
    #1;
    compare_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_red"},   32'(lamp_red),   32'hf);
    check({tag, "_amber"}, 32'(lamp_amber), 32'h0);
    check({tag, "_green"}, 32'(lamp_green), 32'h0);
    check({tag, "_sw"},    32'(switching),  32'h1);
    check({tag, "_err"},   32'(grant_err),  32'h0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from clock edges.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    red_run   = 1;
    amber_run = 0;
  endtask

  // Holds g until green shows g; returns edges counted after the first one.
  task automatic edges_to_green(input logic [3:0] g, output int n);
    n = 0;
    step(g);
    while (lamp_green != g && n < 20) begin
      step(g);
      n++;
    end
  endtask

  function automatic logic [3:0] rand_grant(input logic [3:0] prev);
    int r;
    logic [3:0] one;
    one = 4'b0001;
    r = $urandom_range(0, 9);
    if (r < 6) return prev;
    if (r < 9) return one << $urandom_range(0, 3);
    return 4'($urandom_range(0, 15));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [3:0] g;
    logic [3:0] last_g;

    rst = 1'b1;
    grant = 4'b0000;
    model_reset();
    red_run = 0;
    amber_run = 0;
    #1 check_reset_outputs("reset_no_clock");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    red_run = 1;

    // Cold start: two red cycles, then the first approach goes green.
    step(4'b0001);
    check("start_red", 32'(lamp_red), 32'hf);
    step(4'b0001);
    check("start_green", 32'(lamp_green), 32'h1);
    check("start_red_mask", 32'(lamp_red), 32'he);
    check("start_sw", 32'(switching), 32'h0);
    repeat (3) step(4'b0001);

    // Hand-over: green appears AMBER+ALLRED edges after the sampling edge.
    edges_to_green(4'b0100, n);
    check("handover_latency", 32'(n), 32'(AMBER + ALLRED));
    repeat (2) step(4'b0100);

    // Grant flips every cycle through amber; green follows the last sample.
    step(4'b0010);
    last_g = 4'b0010;
    n = 0;
    while (lamp_green == 4'b0000 && n < 20) begin
      n++;
      g = n[0] ? 4'b1000 : 4'b0010;
      step(g);
      last_g = g;
    end
    check("toggle_latency", 32'(n), 32'(AMBER + ALLRED));
    check("toggle_green", 32'(lamp_green), 32'(last_g));
    repeat (2) step(last_g);

    // Multi-hot grant while green: error pulse, amber, then parked in red.
    step(4'b0011);
    check("multihot_err", 32'(grant_err), 32'h1);
    check("multihot_amber", 32'(lamp_amber), 32'(last_g));
    step(4'b0000);
    check("multihot_err_clear", 32'(grant_err), 32'h0);
    repeat (10) step(4'b0000);
    check("parked_red", 32'(lamp_red), 32'hf);
    step(4'b0001);
    check("parked_release", 32'(lamp_green), 32'h1);
    repeat (2) step(4'b0001);

    // Reset in the second amber cycle aborts straight to all red.
    step(4'b0010);
    step(4'b0010);
    check("second_amber", 32'(lamp_amber), 32'h1);
    pulse_reset("reset_mid_amber");
    edges_to_green(4'b0100, n);
    check("post_reset_latency", 32'(n), 32'(ALLRED - 1));
    repeat (2) step(4'b0100);

    // Same approach re-granted after leaving: full sequence still applies.
    step(4'b1000);
    edges_to_green(4'b0100, n);
    check("regrant_latency", 32'(n), 32'(AMBER + ALLRED - 1));

    // Random grant stream with a few asynchronous resets.
    g = 4'b0100;
    for (int i = 0; i < 10000; i++) begin
      if (i == 2500 || i == 5000 || i == 7500) pulse_reset("reset_random");
      g = rand_grant(g);
      step(g);
    end

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
